reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised multi-port register file, successor to the single-config 32x32 register file of the one-cycle MIPS datapath.
- Generalised data width, address width and read-port count.
- Two write ports with fixed priority and optional write-to-read bypass.
- Optional hardwired-zero register 0.
- Reset/clear via a sequential scrub engine (one entry per cycle) instead of a parallel array reset; a `ready` flag gates use.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
clr_req  input  1  synchronous request to re-scrub the whole array
ready  output  1  high when scrub is complete and the array is usable
rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
wa_en  input  1  write port A enable
wa_addr  input  ADDR_W  write port A address
wa_data  input  DATA_W  write port A data
wb_en  input  1  write port B enable (higher priority)
wb_addr  input  ADDR_W  write port B address
wb_data  input  DATA_W  write port B data

Behaviour:
- FSM states: CLEAR, RUN. Scrub counter `scrub_idx` is ADDR_W bits.
- rst asserted (async): state <= CLEAR, scrub_idx <= 0, ready <= 0; array contents not touched by rst itself.
- CLEAR: each rising edge writes 0 to entry scrub_idx and increments it.
  - When scrub_idx == DEPTH-1, that edge clears the last entry and moves to RUN.
  - ready is a registered output, high exactly in RUN. After rst deasserts, ready rises on the DEPTH-th rising edge.
- clr_req in RUN: next edge enters CLEAR with scrub_idx <= 0 and ready <= 0. clr_req in CLEAR restarts scrub_idx at 0.
- During CLEAR: wa_en/wb_en ignored (writes dropped), and all rd_data = 0.
- RUN writes, on the rising edge:
  - wa_en: mem[wa_addr] <= wa_data.
  - wb_en: mem[wb_addr] <= wb_data.
  - Same address on both ports: B wins, A dropped.
  - ZERO_REG=1: writes to address 0 dropped on both ports.
- Reads are combinational, zero latency, in RUN. Priority per port i, highest first:
  1. ZERO_REG=1 and address 0 -> 0.
  2. BYPASS=1, wb_en, wb_addr matches -> wb_data.
  3. BYPASS=1, wa_en, wa_addr matches -> wa_data.
  4. Otherwise -> mem[addr].
- BYPASS=0: a read returns the pre-edge value; the write is visible the cycle after.
- rst mid-CLEAR or mid-RUN: immediate return to CLEAR, scrub_idx 0, ready 0. rd_data forced to 0 asynchronously.
- No X may propagate on rd_data at any time after rst is asserted.
- Widths: all addresses are full ADDR_W; no wrap logic is needed beyond the counter terminal check.

Test Plan:
- Reset/scrub, defaults (DEPTH=32): assert rst 3 cycles, release -> ready=0 for 31 edges, ready=1 after the 32nd; all 32 entries then read 0.
- Basic write/read, BYPASS=0: write A addr 5 = 0xDEADBEEF -> rd_data port0 at addr 5 = 0xDEADBEEF the next cycle; the same cycle shows the old value 0.
- Dual-write collision: wa and wb both to addr 7 with A=0x1111, B=0x2222 -> mem[7]=0x2222. Repeat with BYPASS=1 -> port1 reading addr 7 shows 0x2222 in the same cycle.
- Zero register: write 0xFFFFFFFF to addr 0 via both ports -> reads of addr 0 return 0 (ZERO_REG=1). With ZERO_REG=0 -> returns 0xFFFFFFFF next cycle.
- Re-scrub: fill addrs 1..31 with their index, pulse clr_req 1 cycle -> ready falls next edge. A write during CLEAR is dropped. After 32 edges ready=1 and all entries read 0.
- Async reset mid-operation: assert rst between clock edges during RUN with wa_en active -> ready=0 and rd_data=0 immediately. The pending write is not applied, and a full 32-cycle scrub follows release.

Source files
------------

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-port register file.
//   - DEPTH = 2**ADDR_W entries of DATA_W bits, NUM_RD combinational read ports.
//   - Two write ports, B has priority over A on an address collision.
//   - Optional hardwired-zero entry 0 (ZERO_REG) and write-to-read bypass (BYPASS).
//   - Contents are cleared by a scrub engine, one entry per clock, after rst
//     or on clr_req; ready is high only once the scrub has finished.
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst      in   asynchronous active-high reset
//   clr_req  in   synchronous request to re-scrub the whole array
//   ready    out  array scrubbed and usable
//   rd_addr  in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  out  packed read data, port i at [i*DATA_W +: DATA_W]
//   wa_*     in   write port A (enable, address, data)
//   wb_*     in   write port B (enable, address, data), higher priority
//
// state | meaning
// CLEAR | scrub in progress: entry scrub_idx zeroed each edge, writes dropped, reads 0
// RUN   | normal operation: writes applied, reads served
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    output logic                       ready,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   scrub_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wa_ok;
    logic                wb_ok;

    // Writes to a hardwired-zero entry are dropped; A loses to B on collision.
    assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));
    assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0))
                         && !(wb_en && (wb_addr == wa_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            scrub_idx <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_req) begin
                        scrub_idx <= '0;
                    end else if (scrub_idx == LAST_IDX) begin
                        state     <= RUN;
                        scrub_idx <= '0;
                        ready     <= 1'b1;
                    end else begin
                        scrub_idx <= scrub_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        scrub_idx <= '0;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    scrub_idx <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset of its own. While rst is held the state is
    // forced to CLEAR, so the only write that can happen is a harmless
    // zeroing of entry 0 and user writes are dropped.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[scrub_idx] <= '0;
        end else begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end

    // Read ports: gated to 0 outside RUN, which also covers an asserted rst
    // because state is reset asynchronously.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] q;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            q = '0;
            if (state == RUN) begin
                if ((ZERO_REG != 0) && (addr == '0))
                    q = '0;
                else if ((BYPASS != 0) && wb_en && (wb_addr == addr))
                    q = wb_data;
                else if ((BYPASS != 0) && wa_en && (wa_addr == addr))
                    q = wa_data;
                else
                    q = mem[addr];
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic [9:0]  rd_addr;
    logic        wa_en, wb_en;
    logic [4:0]  wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;

    logic        ready_a, ready_b;
    logic [63:0] rd_data_a, rd_data_b;

    int n_chk;
    int n_fail;

    // dut: hardwired zero, no bypass.  dut_b: no zero register, bypass on.
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_a),
        .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then step 1 time unit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Counts a full scrub: ready low for 31 edges, high after the 32nd.
    task automatic scrub_wait(input string tag);
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("%s_ready_a_%0d", tag, k), {63'd0, ready_a}, (k == 32) ? 64'd1 : 64'd0);
            chk($sformatf("%s_ready_b_%0d", tag, k), {63'd0, ready_b}, (k == 32) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            #1;
            chk($sformatf("%s_a_%0d", tag, i), rd_data_a, 64'd0);
            chk($sformatf("%s_b_%0d", tag, i), rd_data_b, 64'd0);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clr_req = 1'b0;
        wa_en   = 1'b0;  wa_addr = '0; wa_data = '0;
        wb_en   = 1'b0;  wb_addr = '0; wb_data = '0;
        rd_addr = '0;

        // Reset and initial scrub
        repeat (3) tick();
        chk("rst_ready_a", {63'd0, ready_a}, 64'd0);
        chk("rst_rd_a", rd_data_a, 64'd0);
        chk("rst_rd_b", rd_data_b, 64'd0);
        rst = 1'b0;
        scrub_wait("scrub0");
        all_zero("init_zero");

        // Basic write on port A to address 5
        set_rd(5'd5, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        #1;
        chk("wr5_same_cycle_a", rd_data_a[31:0], 64'd0);
        chk("wr5_same_cycle_b_bypass", rd_data_b[31:0], 64'hDEADBEEF);
        tick();
        wa_en = 1'b0;
        #1;
        chk("wr5_next_a", rd_data_a[31:0], 64'hDEADBEEF);
        chk("wr5_next_b", rd_data_b[31:0], 64'hDEADBEEF);

        // Dual-write collision on address 7
        set_rd(5'd5, 5'd7);
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
        #1;
        chk("coll_same_a", rd_data_a[63:32], 64'd0);
        chk("coll_same_b_bypass", rd_data_b[63:32], 64'h2222);
        tick();
        wa_en = 1'b0; wb_en = 1'b0;
        #1;
        chk("coll_next_a", rd_data_a[63:32], 64'h2222);
        chk("coll_next_b", rd_data_b[63:32], 64'h2222);
        chk("coll_keep5_a", rd_data_a[31:0], 64'hDEADBEEF);

        // Zero register: both ports write all-ones to address 0
        set_rd(5'd0, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        chk("zero_same_a", rd_data_a, 64'd0);
        chk("zero_same_b_bypass", rd_data_b, 64'hFFFFFFFF_FFFFFFFF);
        tick();
        wa_en = 1'b0; wb_en = 1'b0;
        #1;
        chk("zero_next_a", rd_data_a, 64'd0);
        chk("zero_next_b", rd_data_b, 64'hFFFFFFFF_FFFFFFFF);

        // Fill 1..31 with the index, then re-scrub
        for (int i = 1; i < 32; i++) begin
            wa_en = 1'b1; wa_addr = 5'(i); wa_data = 32'(i);
            tick();
        end
        wa_en = 1'b0;
        set_rd(5'd31, 5'd1);
        #1;
        chk("fill_a", rd_data_a, {32'd1, 32'd31});
        chk("fill_b", rd_data_b, {32'd1, 32'd31});
        set_rd(5'd5, 5'd7);
        #1;
        chk("fill_mid_a", rd_data_a, {32'd7, 32'd5});

        set_rd(5'd31, 5'd2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_ready_a", {63'd0, ready_a}, 64'd0);
        chk("clr_ready_b", {63'd0, ready_b}, 64'd0);
        #1;
        chk("clr_rd_a", rd_data_a, 64'd0);
        chk("clr_rd_b", rd_data_b, 64'd0);
        for (int k = 1; k <= 32; k++) begin
            // Write during the last scrub edge: entry 2 is already scrubbed,
            // so only dropping the write leaves it at 0.
            if (k == 32) begin
                wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'hABCD;
            end
            tick();
            if (k == 32) wa_en = 1'b0;
            if (k == 16) begin
                chk("clr_mid_rd_a", rd_data_a, 64'd0);
                chk("clr_mid_rd_b", rd_data_b, 64'd0);
            end
            chk($sformatf("rescrub_ready_a_%0d", k), {63'd0, ready_a}, (k == 32) ? 64'd1 : 64'd0);
        end
        all_zero("rescrub_zero");

        // Asynchronous reset between edges while a write is pending
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h55;
        tick();
        wa_addr = 5'd4; wa_data = 32'h77;
        set_rd(5'd3, 5'd6);
        #1;
        chk("pre_rst_a", rd_data_a, {32'd0, 32'h55});
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ready_a", {63'd0, ready_a}, 64'd0);
        chk("arst_ready_b", {63'd0, ready_b}, 64'd0);
        chk("arst_rd_a", rd_data_a, 64'd0);
        chk("arst_rd_b", rd_data_b, 64'd0);
        tick();
        rst = 1'b0;
        wa_en = 1'b0;
        scrub_wait("scrub_arst");
        set_rd(5'd3, 5'd4);
        #1;
        chk("arst_after_a", rd_data_a, 64'd0);
        chk("arst_after_b", rd_data_b, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
